// File: rtl/multi_ch_deglitch.sv
// N-channel input deglitcher: 2-flop synchroniser plus tick-based qualification per channel.
// Optional per-channel glitch counters are enabled by defining DEGLITCH_GLITCH_CNT_EN.
module multi_ch_deglitch #(
  parameter int   CH   = 4,
  parameter int   TW   = 8,
  parameter logic INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [CH-1:0]     sin,
  input  logic [TW-1:0]     flt_time,
  output logic [CH-1:0]     sout,
  output logic [CH-1:0]     sout_rise,
  output logic [CH-1:0]     sout_fall,
  input  logic              glitch_clr,
  output logic [CH*8-1:0]   glitch_cnt
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [CH-1:0] sync0;
  logic [CH-1:0] sync1;
  logic [CH-1:0] diff;
  logic [CH-1:0] sout_nxt;
  logic [CH-1:0] abort;
  logic [TW-1:0] cnt     [CH];
  logic [TW-1:0] cnt_nxt [CH];
  logic [TW-1:0] flt_last;

  assign diff     = sync1 ^ sout;
  assign flt_last = flt_time - ONE;

  // Compare with >= so a threshold lowered below the running count completes on the next tick.
  always_comb begin
    sout_nxt = sout;
    abort    = '0;
    for (int k = 0; k < CH; k++) begin
      cnt_nxt[k] = cnt[k];
      if (!diff[k]) begin
        cnt_nxt[k] = '0;
        abort[k]   = (cnt[k] != '0);
      end else if (flt_time == '0) begin
        sout_nxt[k] = sync1[k];
        cnt_nxt[k]  = '0;
      end else if (tick) begin
        if (cnt[k] >= flt_last) begin
          sout_nxt[k] = sync1[k];
          cnt_nxt[k]  = '0;
        end else begin
          cnt_nxt[k] = cnt[k] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0     <= {CH{INIT}};
      sync1     <= {CH{INIT}};
      sout      <= {CH{INIT}};
      sout_rise <= '0;
      sout_fall <= '0;
      for (int k = 0; k < CH; k++) cnt[k] <= '0;
    end else begin
      sync0     <= sin;
      sync1     <= sync0;
      sout      <= sout_nxt;
      sout_rise <= sout_nxt & ~sout;
      sout_fall <= ~sout_nxt & sout;
      for (int k = 0; k < CH; k++) cnt[k] <= cnt_nxt[k];
    end
  end

`ifdef DEGLITCH_GLITCH_CNT_EN
  logic [7:0] gcnt [CH];

  // Clear has priority over a coincident increment; counters saturate at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) gcnt[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (glitch_clr)                        gcnt[k] <= '0;
        else if (abort[k] && gcnt[k] != 8'hFF) gcnt[k] <= gcnt[k] + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_gcnt
    assign glitch_cnt[8*k +: 8] = gcnt[k];
  end
`else
  logic unused_glitch;
  assign unused_glitch = glitch_clr | (|abort);
  assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_multi_ch_deglitch.sv
// Directed bench for multi_ch_deglitch (CH=4, TW=8, INIT=0): vector table plus
// hand sequences for threshold shrink, full-scale threshold, reset and glitch saturation.
module tb_multi_ch_deglitch;

`ifdef DEGLITCH_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        tick;
  logic [3:0]  sin;
  logic [7:0]  flt_time;
  logic [3:0]  sout;
  logic [3:0]  sout_rise;
  logic [3:0]  sout_fall;
  logic        glitch_clr;
  logic [31:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  multi_ch_deglitch #(.CH(4), .TW(8), .INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .sin        (sin),
    .flt_time   (flt_time),
    .sout       (sout),
    .sout_rise  (sout_rise),
    .sout_fall  (sout_fall),
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // vector table: one row per clock, expected outputs sampled after the edge
  typedef struct {
    logic [3:0] sin;
    logic       tick;
    logic [7:0] ft;
    logic [3:0] sout;
    logic [3:0] rise;
    logic [3:0] fall;
    int         g0;
  } vec_t;

  vec_t vec_q[$];
  logic [11:0] exp_q[$];

  function automatic void add(input logic [3:0] s, input logic t, input logic [7:0] ft,
                              input logic [3:0] o, input logic [3:0] r, input logic [3:0] f,
                              input int g);
    vec_t v;
    v.sin = s; v.tick = t; v.ft = ft; v.sout = o; v.rise = r; v.fall = f; v.g0 = g;
    vec_q.push_back(v);
  endfunction

  function automatic logic [31:0] gexp(input int n0);
    return GC_EN ? {24'd0, 8'(n0)} : 32'd0;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic glitch_once(input logic clr);
    sin[0] = 1'b0;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    sin[0] = 1'b1;
    step(1'b0);
    step(1'b0);
    glitch_clr = clr;
    step(1'b0);
    glitch_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_w;

    // power-up qualification: flt_time=3, tick every 4 clk
    add(4'hF, 0, 3, 4'h0, 4'h0, 4'h0, 0);
    add(4'hF, 0, 3, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 2; i++) begin
      add(4'hF, 1, 3, 4'h0, 4'h0, 4'h0, 0);
      for (int j = 0; j < 3; j++) add(4'hF, 0, 3, 4'h0, 4'h0, 4'h0, 0);
    end
    add(4'hF, 1, 3, 4'hF, 4'hF, 4'h0, 0);
    add(4'hF, 0, 3, 4'hF, 4'h0, 4'h0, 0);
    // bypass falling edge on all channels
    add(4'h0, 0, 0, 4'hF, 4'h0, 4'h0, 0);
    add(4'h0, 0, 0, 4'hF, 4'h0, 4'h0, 0);
    add(4'h0, 0, 0, 4'h0, 4'h0, 4'hF, 0);
    add(4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    // glitch on ch0 with flt_time=5
    add(4'h1, 0, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 0, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 1, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 0, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 1, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h0, 0, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h0, 1, 5, 4'h0, 4'h0, 4'h0, 0);
    add(4'h0, 0, 5, 4'h0, 4'h0, 4'h0, 1);
    add(4'h0, 0, 5, 4'h0, 4'h0, 4'h0, 1);
    // requalification from zero on ch0 and ch1
    add(4'h3, 0, 5, 4'h0, 4'h0, 4'h0, 1);
    add(4'h3, 0, 5, 4'h0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 4; i++) add(4'h3, 1, 5, 4'h0, 4'h0, 4'h0, 1);
    add(4'h3, 1, 5, 4'h3, 4'h3, 4'h0, 1);
    add(4'h3, 0, 5, 4'h3, 4'h0, 4'h0, 1);
    // falling edge on ch1
    add(4'h1, 0, 5, 4'h3, 4'h0, 4'h0, 1);
    add(4'h1, 0, 5, 4'h3, 4'h0, 4'h0, 1);
    for (int i = 0; i < 4; i++) add(4'h1, 1, 5, 4'h3, 4'h0, 4'h0, 1);
    add(4'h1, 1, 5, 4'h1, 4'h0, 4'h2, 1);
    add(4'h1, 0, 5, 4'h1, 4'h0, 4'h0, 1);
    // bypass toggle of ch2 every 3 clk, tick=0
    add(4'h5, 0, 0, 4'h1, 4'h0, 4'h0, 1);
    add(4'h5, 0, 0, 4'h1, 4'h0, 4'h0, 1);
    add(4'h5, 0, 0, 4'h5, 4'h4, 4'h0, 1);
    add(4'h1, 0, 0, 4'h5, 4'h0, 4'h0, 1);
    add(4'h1, 0, 0, 4'h5, 4'h0, 4'h0, 1);
    add(4'h1, 0, 0, 4'h1, 4'h0, 4'h4, 1);
    add(4'h5, 0, 0, 4'h1, 4'h0, 4'h0, 1);
    add(4'h5, 0, 0, 4'h1, 4'h0, 4'h0, 1);
    add(4'h5, 0, 0, 4'h5, 4'h4, 4'h0, 1);
    add(4'h5, 0, 0, 4'h5, 4'h0, 4'h0, 1);

    // reset with sin held high
    rst = 1'b1; tick = 1'b0; sin = 4'hF; flt_time = 8'd3; glitch_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_sout", 64'(sout), 64'h0);
    check("reset_strobes", 64'({sout_rise, sout_fall}), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold_sout", 64'(sout), 64'h0);
    check("reset_glitch", 64'(glitch_cnt), 64'h0);
    rst = 1'b1;

    for (int i = 0; i < vec_q.size(); i++) begin
      sin      = vec_q[i].sin;
      flt_time = vec_q[i].ft;
      exp_q.push_back({vec_q[i].sout, vec_q[i].rise, vec_q[i].fall});
      step(vec_q[i].tick);
      exp_w = exp_q.pop_front();
      check($sformatf("row%0d_out", i), 64'({sout, sout_rise, sout_fall}), 64'(exp_w));
      check($sformatf("row%0d_glitch", i), 64'(glitch_cnt), 64'(gexp(vec_q[i].g0)));
    end

    // threshold shrink: flt_time 10 -> 4 with cnt=7 on ch3
    flt_time = 8'd10; sin = 4'hD;
    step(1'b0); step(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1);
    check("shrink_before", 64'(sout), 64'h5);
    flt_time = 8'd4;
    step(1'b0);
    check("shrink_no_tick", 64'(sout), 64'h5);
    step(1'b1);
    check("shrink_flip", 64'({sout, sout_rise}), 64'hD8);

    // full-scale threshold: 255 ticks on ch3, no wrap
    flt_time = 8'd255; sin = 4'h5;
    step(1'b0); step(1'b0);
    for (int i = 0; i < 254; i++) step(1'b1);
    check("ft255_at254", 64'({sout, sout_fall}), 64'hD0);
    step(1'b1);
    check("ft255_at255", 64'({sout, sout_fall}), 64'h58);
    step(1'b1);
    check("ft255_after", 64'({sout, sout_rise, sout_fall}), 64'h500);

    // reset in mid-qualification (cnt=3 on ch3)
    flt_time = 8'd5; sin = 4'hD;
    step(1'b0); step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    #3 rst = 1'b0;
    #1;
    check("midrst_sout", 64'({sout, sout_rise, sout_fall}), 64'h000);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0);
    check("midrst_release", 64'({sout, sout_rise, sout_fall}), 64'h000);
    step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("midrst_restart_4", 64'(sout), 64'h0);
    step(1'b1);
    check("midrst_restart_5", 64'({sout, sout_rise}), 64'hDD);
    check("midrst_glitch", 64'(glitch_cnt), 64'h0);

    // glitch counter saturation and clear on ch0
    for (int i = 0; i < 254; i++) glitch_once(1'b0);
    check("gsat_254", 64'(glitch_cnt), 64'(gexp(254)));
    glitch_once(1'b0);
    check("gsat_255", 64'(glitch_cnt), 64'(gexp(255)));
    for (int i = 0; i < 5; i++) glitch_once(1'b0);
    check("gsat_hold", 64'(glitch_cnt), 64'(gexp(255)));
    check("gsat_sout", 64'(sout), 64'hD);
    glitch_clr = 1'b1;
    step(1'b0);
    glitch_clr = 1'b0;
    check("gclr", 64'(glitch_cnt), 64'h0);
    glitch_once(1'b1);
    check("gclr_wins", 64'(glitch_cnt), 64'h0);
    glitch_once(1'b0);
    check("gclr_then_inc", 64'(glitch_cnt), 64'(gexp(1)));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_ch_deglitch.md
Name: multi_ch_deglitch

Overview:
- N-channel successor to the single-channel pulse filter. Each input is synchronised, then qualified.
- An output level changes only after its input has held the opposite level for a programmable number of timebase ticks.
- Sits between the raw gate-drive / fault inputs of the serial inverter and the control logic.
- Adds over the previous generation: parametrised channel count and counter width, runtime threshold, per-channel edge strobes, defined reset level, and a zero-threshold bypass.

Parameters:
- CH, 4, number of independent channels.
- TW, 8, width of the filter-time threshold and of each per-channel tick counter.
- INIT, 1'b0, reset level of every synchroniser stage and every sout bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle timebase strobe (e.g. one per 600 ns). Counters advance only when tick=1.
- sin  in  CH  raw asynchronous inputs.
- flt_time  in  TW  qualification threshold in ticks, shared by all channels. Treated as quasi-static.
- sout  out  CH  filtered levels.
- sout_rise  out  CH  one-cycle pulse when the corresponding sout goes 0->1.
- sout_fall  out  CH  one-cycle pulse when the corresponding sout goes 1->0.
- glitch_clr  in  1  clears the glitch counters (optional feature).
- glitch_cnt  out  CH*8  per-channel 8-bit glitch counters, channel k at [8k+7:8k] (optional feature).

Behaviour:
- Reset (rst=0, async):
  - sync stages = INIT, sout = INIT.
  - cnt = 0; sout_rise = sout_fall = 0; glitch_cnt = 0.
  - Release produces no edge pulse.
- Per channel: 2-flop synchroniser gives s = sync[1]. All logic below uses s.
- Define diff = (s != sout).
- diff=0:
  - cnt <= 0, covering both idle and an aborted qualification.
  - If cnt was nonzero, the abort counts as a glitch (optional feature).
- diff=1, tick=0: cnt holds.
- diff=1, tick=1:
  - If cnt == flt_time-1: sout <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- flt_time == 0 (bypass): sout <= s on the next clk whenever diff=1, regardless of tick. cnt stays 0.
- Latency: a clean input step reaches sout 2 clk (sync) + flt_time ticks + 1 clk later. Tick phase adds up to one tick period of jitter.
- Any return of s to the sout level before qualification completes restarts qualification from 0 ticks.
- Symmetric: rising and falling edges use the same threshold.
- sout_rise / sout_fall: registered. Asserted in the cycle after sout changes, for exactly 1 clk. Never both set on one channel.
- Counter width is TW. flt_time = 2^TW-1 is legal; cnt never wraps because it clears at the threshold.
- flt_time lowered mid-qualification with cnt >= new flt_time:
  - Qualification completes on the next tick with diff=1 (compare is cnt >= flt_time-1).
  - Never a wrap.
- Channels are fully independent; simultaneous events on all channels are handled in the same cycle.

Optional Feature:
- Macro: DEGLITCH_GLITCH_CNT_EN.
- Defined:
  - Each channel has an 8-bit saturating counter, incremented by 1 in the cycle where diff=0 and cnt!=0.
  - Saturates at 255.
  - glitch_clr=1 zeroes all counters. If a clear and an increment coincide, the clear wins.
- Not defined:
  - glitch_cnt is driven constant 0 and glitch_clr is ignored.
  - No counter flops are synthesised; ports remain for a stable interface.

Test Plan:
- Reset with INIT=0, sin=4'hF held through release: sout=0 immediately after reset. With flt_time=3 and tick every 4 clk, sout=4'hF after exactly 3 ticks past sync. One sout_rise pulse per channel.
- Glitch: flt_time=5, sin[0] high for 2 ticks then low -> sout[0] stays 0, cnt[0] returns 0. With DEGLITCH_GLITCH_CNT_EN, glitch_cnt[7:0]=1.
- Falling edge: sout[1]=1, sin[1] low for 5 ticks with flt_time=5 -> sout[1]=0 on the 5th tick, sout_fall[1] high for 1 clk, sout_rise[1]=0.
- Bypass: flt_time=0, toggle sin[2] each 3 clk with tick=0 -> sout[2] follows s with 1 clk delay.
- Threshold shrink: flt_time=10, cnt=7, set flt_time=4 -> sout flips on the next tick. Repeat with flt_time=255 and a 255-tick stable input -> flips at exactly 255, no wrap.
- Reset mid-qualification (cnt=3, rst pulsed low) -> sout=INIT, cnt=0, no strobe. Qualification restarts from 0 after release. Glitch counter at 255 plus another glitch stays 255; glitch_clr -> 0.
